// File: rtl/axi_coalesce_pkg.sv
// Shared types and sizing helpers for the AXI write coalescer.
package axi_coalesce_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StAw,
    StWdata,
    StWresp
  } state_e;

  // Index width that stays legal for n <= 1.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bytes covered by one full master burst.
  function automatic int unsigned win_bytes(input int unsigned burst_len,
                                            input int unsigned m_dw);
    return burst_len * m_dw / 8;
  endfunction

  // Narrow lanes per wide beat.
  function automatic int unsigned lanes(input int unsigned m_dw, input int unsigned s_dw);
    return m_dw / s_dw;
  endfunction

endpackage

// File: rtl/axi_coalesce_w_buffer.sv
// One-window byte buffer with a per-byte valid map: narrow write port, wide beat read port.
module coalesce_buffer
  import axi_coalesce_pkg::*;
#(
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 256,
  parameter int unsigned SlotW              = idx_w(win_bytes(C_M_AXI_BURST_LEN,
                                                    C_M_AXI_DATA_WIDTH) / (C_S_AXI_DATA_WIDTH / 8)),
  parameter int unsigned BeatW              = idx_w(C_M_AXI_BURST_LEN)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_en,
  input  logic [SlotW-1:0]                wr_slot,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb,
  input  logic [BeatW-1:0]                rd_beat,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] rd_strb,
  output logic                            full,
  input  logic                            clear
);

  localparam int Win = int'(win_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH));
  localparam int Sb  = int'(C_S_AXI_DATA_WIDTH / 8);
  localparam int Mb  = int'(C_M_AXI_DATA_WIDTH / 8);

  logic [7:0]     mem_q [Win];
  logic [Win-1:0] map_q;
  logic [Win-1:0] wr_mask;

  // Bytes touched by this cycle's write.
  always_comb begin
    wr_mask = '0;
    if (wr_en) begin
      for (int b = 0; b < Sb; b++) begin
        wr_mask[int'(wr_slot) * Sb + b] = wr_strb[b];
      end
    end
  end

  // Full including the write in flight, so the flush can follow the last merge directly.
  assign full = &(map_q | wr_mask);

  // Byte storage; contents are only meaningful where the map is set, so no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < Sb; b++) begin
      if (wr_en && wr_strb[b]) begin
        mem_q[int'(wr_slot) * Sb + b] <= wr_data[8*b +: 8];
      end
    end
  end

  // Valid map accumulates strobes until the window is retired.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      map_q <= '0;
    end else begin
      map_q <= map_q | wr_mask;
    end
  end

  // Beat read mux.
  always_comb begin
    rd_data = '0;
    rd_strb = '0;
    for (int i = 0; i < Mb; i++) begin
      rd_data[8*i +: 8] = mem_q[int'(rd_beat) * Mb + i];
      rd_strb[i]        = map_q[int'(rd_beat) * Mb + i];
    end
  end

endmodule

// File: rtl/axi_coalesce_w.sv
// Merges single-beat narrow AXI writes into one aligned window and retires it as a full wide burst.
module axi_coalesce_w
  import axi_coalesce_pkg::*;
#(
  parameter int unsigned C_M_AXI_BURST_LEN   = 16,
  parameter int unsigned C_M_AXI_ID_WIDTH    = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 48,
  parameter int unsigned C_S_AXI_DATA_WIDTH  = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH  = 256,
  parameter int unsigned C_FLUSH_TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awlock,
  input  logic [3:0]                      s_axi_awcache,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awqos,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_M_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awlock,
  output logic [3:0]                      m_axi_awcache,
  output logic [2:0]                      m_axi_awprot,
  output logic [3:0]                      m_axi_awqos,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic                            flush,
  output logic                            idle,
  output logic                            wr_err
);

  localparam int unsigned SbLg     = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int unsigned WinLg    = $clog2(win_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH));
  localparam int unsigned SlotW    = WinLg - SbLg;
  localparam int unsigned BeatW    = idx_w(C_M_AXI_BURST_LEN);
  localparam int unsigned TmoW     = idx_w(C_FLUSH_TIMEOUT + 1);
  localparam int unsigned TmoLast  = (C_FLUSH_TIMEOUT > 0) ? C_FLUSH_TIMEOUT - 1 : 0;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(C_M_AXI_BURST_LEN - 1);

  state_e                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [TmoW-1:0]               cnt_q, cnt_d;
  logic [BeatW-1:0]              beat_q, beat_d;
  logic                          bvalid_q;
  logic                          wr_err_q;

  logic [C_M_AXI_ADDR_WIDTH-1:0] win_base;
  logic                          req, hit, accept, buf_full, buf_clear, tmo_hit;

  logic unused;
  assign unused = ^{s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                    s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awaddr[SbLg-1:0],
                    s_axi_wlast, m_axi_bid};

  assign win_base = {s_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:WinLg], {WinLg{1'b0}}};
  assign hit      = (win_base == base_q);
  assign req      = rstn && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
  // The counter value excludes the current cycle, hence the compare against one less.
  assign tmo_hit  = (C_FLUSH_TIMEOUT != 0) && (cnt_q == TmoW'(TmoLast));

  coalesce_buffer #(
    .C_M_AXI_BURST_LEN  (C_M_AXI_BURST_LEN),
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_M_AXI_DATA_WIDTH (C_M_AXI_DATA_WIDTH),
    .SlotW              (SlotW),
    .BeatW              (BeatW)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (accept),
    .wr_slot (s_axi_awaddr[WinLg-1:SbLg]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_beat (beat_q),
    .rd_data (m_axi_wdata),
    .rd_strb (m_axi_wstrb),
    .full    (buf_full),
    .clear   (buf_clear)
  );

  // Next-state, slave accept and buffer control.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    accept    = 1'b0;
    buf_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        beat_d = '0;
        if (req) begin
          accept  = 1'b1;
          base_d  = win_base;
          state_d = StAccum;
        end
      end
      StAccum: begin
        accept = req && hit;
        cnt_d  = accept ? '0 : cnt_q + 1'b1;
        // A miss is not accepted; it waits until the window is retired.
        if ((req && !hit) || flush || buf_full || tmo_hit) begin
          state_d = StAw;
        end
      end
      StAw: begin
        beat_d = '0;
        if (m_axi_awready) state_d = StWdata;
      end
      StWdata: begin
        if (m_axi_wready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) state_d = StWresp;
        end
      end
      StWresp: begin
        if (m_axi_bvalid) begin
          buf_clear = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, posted-response and error registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      base_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      bvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      if (accept) begin
        bvalid_q <= 1'b1;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (state_q == StWresp && m_axi_bvalid && m_axi_bresp != 2'b00) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  assign s_axi_awready = accept;
  assign s_axi_wready  = accept;
  assign s_axi_bid     = '0;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = base_q;
  assign m_axi_awlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = (state_q == StAw);
  assign m_axi_wvalid  = (state_q == StWdata);
  assign m_axi_wlast   = (state_q == StWdata) && (beat_q == LastBeat);
  assign m_axi_bready  = (state_q == StWresp);

  assign idle   = (state_q == StIdle);
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_axi_coalesce_w.sv
// Directed bench for axi_coalesce_w with a simple memory-side responder.
module tb_axi_coalesce_w;

  logic         clk = 1'b0;
  logic         rstn;
  logic [0:0]   s_awid = '0;
  logic [47:0]  s_awaddr;
  logic         s_awvalid, s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid, s_wready;
  logic [0:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bvalid, s_bready;
  logic [0:0]   m_awid;
  logic [47:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize, m_awprot;
  logic [1:0]   m_awburst;
  logic         m_awlock;
  logic [3:0]   m_awcache, m_awqos;
  logic         m_awvalid, m_awready;
  logic [255:0] m_wdata;
  logic [31:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;
  logic         flush, idle, wr_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int b_pend   = 0;
  int b_done   = 0;
  int beat_cnt = 0;
  int wlast_err = 0;
  int acc_viol = 0;
  bit stall_en = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [22:0] aw_attr;
  logic [47:0]  aw_addr [$];
  int           aw_cyc [$];
  logic [255:0] beat_data [$];
  logic [31:0]  beat_strb [$];

  axi_coalesce_w dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(8'd0), .s_axi_awsize(3'd2),
    .s_axi_awburst(2'b01), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(1'b1), .s_axi_wvalid(s_wvalid),
    .s_axi_wready(s_wready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid),
    .s_axi_bready(s_bready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache),
    .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(1'b0), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .flush(flush), .idle(idle), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side responder: ready generation and B responses after each wlast.
  always begin
    @(posedge clk);
    #1;
    m_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    m_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    m_bvalid  = (b_pend > 0);
    m_bresp   = (b_pend > 0) ? bresp_cfg : 2'b00;
  end

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_awvalid && m_awready) begin
        aw_addr.push_back(m_awaddr);
        aw_cyc.push_back(cyc);
        aw_attr <= {m_awlen, m_awsize, m_awburst, m_awcache, m_awid, m_awlock, m_awprot, m_awqos};
      end
      if (m_wvalid && m_wready) begin
        beat_data.push_back(m_wdata);
        beat_strb.push_back(m_wstrb);
        if (m_wlast != ((beat_cnt % 16) == 15)) wlast_err <= wlast_err + 1;
        beat_cnt <= beat_cnt + 1;
      end
      b_pend <= b_pend + ((m_wvalid && m_wready && m_wlast) ? 1 : 0)
                       - ((m_bvalid && m_bready) ? 1 : 0);
      if (m_bvalid && m_bready) b_done <= b_done + 1;
      if (s_bvalid && s_awready) acc_viol <= acc_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single narrow write; returns at posedge+1 after acceptance.
  task automatic s_write(input logic [47:0] a, input logic [31:0] d, input logic [3:0] st);
    bit ok = 1'b0;
    int n = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while (!ok && n < 3000) begin
      @(negedge clk);
      if (s_awready && s_wready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      n++;
      @(posedge clk);
      #1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!ok) check($sformatf("accept_%0h", a), 256'(ok), 256'(1));
  endtask

  task automatic pulse_flush(output int fc);
    flush = 1'b1;
    fc = cyc;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (b_done < n && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("bursts_done_%0d", n), 256'(b_done), 256'(n));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp;
    logic [31:0]  orstrb;
    int fc;
    rstn = 1'b0; flush = 1'b0; s_bready = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 256'(idle), 256'(1));
    check("rst_m_awvalid", 256'(m_awvalid), 256'(0));
    check("rst_m_wvalid", 256'(m_wvalid), 256'(0));
    check("rst_s_bvalid", 256'(s_bvalid), 256'(0));
    check("rst_s_awready", 256'(s_awready), 256'(0));
    check("rst_wr_err", 256'(wr_err), 256'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full window of sequential words flushes on its own.
    for (int i = 0; i < 128; i++) s_write(48'h1000 + 48'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
    wait_b(1);
    check("t1_awaddr", 256'(aw_addr[0]), 256'(48'h1000));
    check("t1_awattr", 256'(aw_attr), 256'({8'd15, 3'd5, 2'b01, 4'b0010, 1'b0, 1'b0, 3'd0, 4'd0}));
    check("t1_nbeats", 256'(beat_data.size()), 256'(16));
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 8; j++) exp[32*j +: 32] = 32'hC0DE_0000 + 32'(8 * k + j);
      check($sformatf("t1_data%0d", k), beat_data[k], exp);
      check($sformatf("t1_strb%0d", k), 256'(beat_strb[k]), 256'(32'hFFFF_FFFF));
    end
    check("t1_wlast", 256'(wlast_err), 256'(0));

    // Miss stalls behind the flush of the open window.
    s_write(48'h1000, 32'h1234_5678, 4'hF);
    s_write(48'h2000, 32'h9ABC_DEF0, 4'hF);
    check("t2_stalled_until_idle", 256'(b_done), 256'(2));
    check("t2_awaddr", 256'(aw_addr[1]), 256'(48'h1000));
    check("t2_strb0", 256'(beat_strb[16]), 256'(32'h0000_000F));
    check("t2_data0", 256'(beat_data[16][31:0]), 256'(32'h1234_5678));
    orstrb = '0;
    for (int k = 17; k < 32; k++) orstrb = orstrb | beat_strb[k];
    check("t2_other_strb", 256'(orstrb), 256'(0));
    pulse_flush(fc);
    wait_b(3);
    check("t2_awaddr2", 256'(aw_addr[2]), 256'(48'h2000));
    check("t2_strb2", 256'(beat_strb[32]), 256'(32'h0000_000F));
    check("t2_data2", 256'(beat_data[32][31:0]), 256'(32'h9ABC_DEF0));

    // Byte merge within one word, later write wins per byte.
    s_write(48'h1004, 32'hAAAA_1111, 4'h3);
    s_write(48'h1004, 32'h2222_BBBB, 4'hC);
    pulse_flush(fc);
    wait_b(4);
    check("t3_aw_latency", 256'(aw_cyc[3] - fc), 256'(1));
    check("t3_strb", 256'(beat_strb[48]), 256'(32'h0000_00F0));
    check("t3_word", 256'(beat_data[48][63:32]), 256'(32'h2222_1111));

    // Timeout flush, then flush in IDLE does nothing.
    s_write(48'h3000, 32'h5555_AAAA, 4'hF);
    wait_b(5);
    check("t4_timeout_latency", 256'(aw_cyc[4] - acc_cyc), 256'(65));
    pulse_flush(fc);
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_aw_in_idle", 256'(aw_addr.size()), 256'(5));
    check("t4_idle", 256'(idle), 256'(1));

    // Stalled memory side and held slave B.
    stall_en = 1'b1;
    s_bready = 1'b0;
    s_write(48'h4000, 32'hD000_0000, 4'hF);
    s_awaddr = 48'h4004; s_wdata = 32'hD000_0001; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5_hold_ready%0d", i), 256'(s_awready), 256'(0));
      @(posedge clk);
      #1;
    end
    check("t5_bvalid_held", 256'(s_bvalid), 256'(1));
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    for (int i = 1; i < 16; i++) s_write(48'h4000 + 48'(4 * i), 32'hD000_0000 + 32'(i), 4'hF);
    pulse_flush(fc);
    wait_b(6);
    check("t5_nbeats", 256'(beat_data.size()), 256'(96));
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) exp[32*j +: 32] = 32'hD000_0000 + 32'(8 * k + j);
      check($sformatf("t5_data%0d", k), beat_data[80 + k], exp);
      check($sformatf("t5_strb%0d", k), 256'(beat_strb[80 + k]), 256'(32'hFFFF_FFFF));
    end
    check("t5_strb2", 256'(beat_strb[82]), 256'(0));
    check("t5_accept_viol", 256'(acc_viol), 256'(0));
    check("t5_wlast", 256'(wlast_err), 256'(0));
    stall_en = 1'b0;

    // Sticky error response.
    bresp_cfg = 2'b10;
    s_write(48'h5000, 32'h0BAD_0BAD, 4'hF);
    pulse_flush(fc);
    wait_b(7);
    check("t6_wr_err_set", 256'(wr_err), 256'(1));
    bresp_cfg = 2'b00;
    s_write(48'h6000, 32'h600D_600D, 4'hF);
    pulse_flush(fc);
    wait_b(8);
    check("t6_wr_err_sticky", 256'(wr_err), 256'(1));
    check("t6_idle", 256'(idle), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_coalesce_w.md
# axi_coalesce_w

Write-side counterpart of the read burst aggregator in the SpMV kernel utility set. Accepts single-beat narrow AXI writes (typically 32-bit result words from the SpMV datapath), merges them into a local buffer covering one aligned burst window, and flushes that window to memory as one full-length wide AXI write burst with byte strobes. Sits between the SpMV result writer and the wide memory-side AXI interconnect port.

## Interface
- C_M_AXI_BURST_LEN, 16, beats per master burst
- C_M_AXI_ID_WIDTH, 1, AXI ID width (both sides)
- C_M_AXI_ADDR_WIDTH, 48, address width (both sides)
- C_S_AXI_DATA_WIDTH, 32, slave data width
- C_M_AXI_DATA_WIDTH, 256, master data width; must be a multiple of C_S_AXI_DATA_WIDTH
- C_FLUSH_TIMEOUT, 64, idle cycles in ACCUM before forced flush; 0 disables
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}/awready  slave AW; only addr/valid used; awlen must be 0
- s_axi_w{data,strb,last,valid}/wready  slave W, C_S_AXI_DATA_WIDTH data
- s_axi_b{id,resp,valid}/bready  slave B; bid=0, bresp=OKAY
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}/awready  master AW; id=0, len=C_M_AXI_BURST_LEN-1, size=log2(C_M_AXI_DATA_WIDTH/8), burst=INCR, cache=4'b0010, others 0
- m_axi_w{data,strb,last,valid}/wready  master W
- m_axi_b{id,resp,valid}/bready  master B
- flush  in  1  request flush of current window
- idle  out  1  buffer empty, no burst in flight
- wr_err  out  1  sticky: a master bresp != OKAY was seen; cleared by reset only

## Operation
- Window WIN = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8 bytes (512 default); base = addr & ~(WIN-1). Slave addr low log2(C_S_AXI_DATA_WIDTH/8) bits ignored.
- Buffer: WIN bytes data + WIN-bit strobe map; slot = (addr-base)/(C_S_AXI_DATA_WIDTH/8).
- States: IDLE, ACCUM, AW, WDATA, WRESP.
- Slave accept: awvalid&wvalid both high, state IDLE or (ACCUM and hit), no s_axi_b pending; awready=wready=1 that cycle only (combinational on those conditions). Else both ready low.
- IDLE accept: latch base, write lane, set strobes -> ACCUM.
- ACCUM accept (hit): merge bytes where wstrb=1; later write to same byte wins; strobe map ORed.
- ACCUM flush condition: slave miss pending (awvalid&wvalid, not hit), flush=1, strobe map all ones (including this cycle's write), or timeout counter == C_FLUSH_TIMEOUT -> AW. Miss write stays stalled until back in IDLE.
- AW: m_axi_awvalid=1, awaddr=base until awready -> WDATA.
- WDATA: beat k = buffer bytes [k*M/8 +: M/8], wstrb = matching strobe bits; all C_M_AXI_BURST_LEN beats sent even if strobes zero; wlast on final beat -> WRESP.
- WRESP: bready=1; on bvalid, set wr_err if bresp!=0, clear strobe map -> IDLE.
- flush in IDLE: ignored. idle=1 only in IDLE.
- Posted writes: slave B returned on accept, independent of memory completion.

## Timing
- Reset: all valids 0, all readys 0, state IDLE, strobe map 0, timeout 0, wr_err 0, idle 1.
- s_axi_bvalid rises cycle after accept, held until bready; no new accept while held.
- Flush condition in cycle N -> m_axi_awvalid high in N+1.
- WDATA: m_axi_wvalid high from cycle after AW handshake; one beat per wready cycle; minimum burst = BURST_LEN cycles.
- Timeout counter: resets on every accept and on ACCUM entry, increments each ACCUM cycle otherwise.
- Simultaneous accept (hit) and flush: write included, then flush.
- Reset mid-burst: buffer discarded, state IDLE; permitted only with downstream also reset.

## Structure
- Package axi_coalesce_pkg: state enum, WIN_BYTES, LANES = C_M/C_S, beat-index and slot widths helper (clog2).
- Sub-module coalesce_buffer: byte-strobed write port (slot, data, strb), beat read port (data + strobes), all-full flag, clear.

## Test plan
- 128 sequential 32-bit writes at 0x1000..0x11FC, wstrb=F -> full-window auto-flush: one AW at 0x1000 len=15, 16 beats all wstrb=0xFFFFFFFF, data matches.
- Writes to 0x1000 then 0x2000 -> first burst at 0x1000 with only beat 0 strb=0x0000000F; second write stalls until IDLE, then starts window 0x2000.
- Two writes to 0x1004 with strb=3 then C, data 0xAAAA_1111 / 0x2222_BBBB -> memory word 0x2222_1111.
- Single write then nothing, C_FLUSH_TIMEOUT=64 -> AW issued 65 cycles after accept; flush=1 in IDLE -> no AW.
- m_axi_awready/wready randomly stalled, s_axi_bready held low 5 cycles -> no beat loss, no accept while bvalid held.
- Master bresp=SLVERR -> wr_err=1 and stays 1 through subsequent OKAY bursts.
